// File: rtl/counter_ctrl_if.sv
// Control/status bundle for counter_ctrl: start/stop/mode/limit in, count and
// state flags out.
interface counter_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tick;

  modport master (
    output start, stop, periodic, limit,
    input  count, busy, done, tick
  );

  modport slave (
    input  start, stop, periodic, limit,
    output count, busy, done, tick
  );
endinterface

// File: rtl/counter_ctrl.sv
// Start/stop counter with one-shot or auto-reload mode; counts 0..limit and
// pulses tick on each terminal count.
module counter_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input logic           clk,
  input logic           reset,
  counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             tick_q, tick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;

    // stop beats start and a coincident terminal count
    if (bus.stop) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_d = '0;
          if (bus.start) begin
            limit_d    = bus.limit;
            periodic_d = bus.periodic;
            state_d    = StRun;
          end
        end
        StRun: begin
          if (count_q == limit_q) begin
            tick_d = 1'b1;
            if (periodic_q) begin
              count_d = '0;
            end else begin
              state_d = StDone;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        StDone: begin
          if (bus.start) begin
            limit_d    = bus.limit;
            periodic_d = bus.periodic;
            count_d    = '0;
            state_d    = StRun;
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.tick  = tick_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random
// stimulus against an elapsed-time reference model.
module tb_counter_ctrl;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic reset;

  counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles elapsed since the accepted start, plus the latched settings.
  bit m_active;
  bit m_per;
  int m_lim;
  int m_elapsed;
  bit m_tick;

  function automatic bit m_done();
    return m_active && !m_per && (m_elapsed > m_lim);
  endfunction

  function automatic bit m_busy();
    return m_active && !m_done();
  endfunction

  function automatic int m_count();
    if (!m_active) return 0;
    if (m_per) return m_elapsed % (m_lim + 1);
    return (m_elapsed > m_lim) ? m_lim : m_elapsed;
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_per     = 1'b0;
    m_lim     = 0;
    m_elapsed = 0;
    m_tick    = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit per, input int lim);
    m_tick = 1'b0;
    if (sp) begin
      m_active = 1'b0;
    end else if (!m_active || m_done()) begin
      if (st) begin
        m_active  = 1'b1;
        m_elapsed = 0;
        m_lim     = lim;
        m_per     = per;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed % (m_lim + 1) == 0) m_tick = 1'b1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".count"}, 32'(bus.count), 32'(m_count()));
    check_eq({tag, ".busy"},  32'(bus.busy),  32'(m_busy()));
    check_eq({tag, ".done"},  32'(bus.done),  32'(m_done()));
    check_eq({tag, ".tick"},  32'(bus.tick),  32'(m_tick));
  endtask

  // Called just after a falling edge; drives inputs, steps one cycle, checks.
  task automatic cycle(input string tag, input bit st, input bit sp, input bit per,
                       input int lim);
    bus.start    = st;
    bus.stop     = sp;
    bus.periodic = per;
    bus.limit    = WIDTH'(lim);
    @(posedge clk);
    model_edge(st, sp, per, lim);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n, input bit per, input int lim,
                             output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      cycle(tag, 1'b0, 1'b0, per, lim);
      if (bus.tick) ticks++;
    end
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int ticks;

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.periodic = 1'b0;
    bus.limit    = '0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // One-shot, limit 5
    cycle("os_start", 1'b1, 1'b0, 1'b0, 5);
    idle_cycles("os_run", 8, 1'b0, 5, ticks);
    check_eq("os_ticks", 32'(ticks), 32'd1);
    check_eq("os_hold", 32'(bus.count), 32'd5);
    check_eq("os_done", 32'(bus.done), 32'd1);

    // Periodic, limit 3
    cycle("stop", 1'b0, 1'b1, 1'b0, 0);
    cycle("per_start", 1'b1, 1'b0, 1'b1, 3);
    idle_cycles("per_run", 12, 1'b1, 3, ticks);
    check_eq("per_ticks", 32'(ticks), 32'd3);

    // Abort at count 4 with start also high
    cycle("stop", 1'b0, 1'b1, 1'b0, 0);
    cycle("ab_start", 1'b1, 1'b0, 1'b0, 9);
    idle_cycles("ab_run", 4, 1'b0, 9, ticks);
    check_eq("ab_cnt4", 32'(bus.count), 32'd4);
    cycle("ab_stop", 1'b1, 1'b1, 1'b0, 9);
    check_eq("ab_busy", 32'(bus.busy), 32'd0);
    check_eq("ab_tick", 32'(bus.tick), 32'd0);

    // limit 0 periodic: tick every cycle
    cycle("l0p_start", 1'b1, 1'b0, 1'b1, 0);
    idle_cycles("l0p_run", 5, 1'b1, 0, ticks);
    check_eq("l0p_ticks", 32'(ticks), 32'd5);

    // limit 0 one-shot: done one edge after busy
    cycle("stop", 1'b0, 1'b1, 1'b0, 0);
    cycle("l0o_start", 1'b1, 1'b0, 1'b0, 0);
    check_eq("l0o_busy", 32'(bus.busy), 32'd1);
    cycle("l0o_end", 1'b0, 1'b0, 1'b0, 0);
    check_eq("l0o_done", 32'(bus.done), 32'd1);

    // Full range, limit 15
    cycle("stop", 1'b0, 1'b1, 1'b0, 0);
    cycle("full_start", 1'b1, 1'b0, 1'b0, 15);
    idle_cycles("full_run", 15, 1'b0, 15, ticks);
    check_eq("full_max", 32'(bus.count), 32'd15);
    idle_cycles("full_end", 2, 1'b0, 15, ticks);
    check_eq("full_ticks", 32'(ticks), 32'd1);

    // Restart from DONE; limit changes during RUN are ignored
    cycle("stop", 1'b0, 1'b1, 1'b0, 0);
    cycle("rs_start", 1'b1, 1'b0, 1'b0, 2);
    idle_cycles("rs_os", 3, 1'b0, 2, ticks);
    check_eq("rs_done", 32'(bus.done), 32'd1);
    cycle("rs_restart", 1'b1, 1'b0, 1'b1, 4);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("rs_run", 1'b0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      if (bus.tick) ticks++;
    end
    check_eq("rs_ticks", 32'(ticks), 32'd2);

    // Async reset mid-run at count 7
    cycle("stop", 1'b0, 1'b1, 1'b0, 0);
    cycle("ar_start", 1'b1, 1'b0, 1'b0, 9);
    idle_cycles("ar_run", 7, 1'b0, 9, ticks);
    check_eq("ar_cnt7", 32'(bus.count), 32'd7);
    async_reset_pulse("ar_reset");
    cycle("ar_restart", 1'b1, 1'b0, 1'b0, 3);
    check_eq("ar_busy", 32'(bus.busy), 32'd1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset_pulse("rnd_reset");
      end else begin
        cycle("rnd",
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
